cevre_veriyolu_denetleyici: RTL and testbench

Parametrised peripheral-bus controller between the core's data port and N memory-mapped peripherals (UART, SPI, PWM, ...). It registers one core request, decodes the target device from the address, and drives a valid/busy handshake to that device. It then waits for the device response and returns data or an error to the core. A timeout guards against hung devices.

---
 rtl/cevre_veriyolu_denetleyici_pkg.sv | 28 ++
 rtl/cevre_veriyolu_denetleyici_zaman_asimi_sayaci.sv | 29 ++
 rtl/cevre_veriyolu_denetleyici.sv | 158 +++++++++++++++
 tb/tb_cevre_veriyolu_denetleyici.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cevre_veriyolu_denetleyici_pkg.sv
// Shared definitions for the peripheral-bus controller: FSM state codes,
// default address-decode geometry, device indices and the latched request.
package cevre_veriyolu_denetleyici_pkg;

   // FSM state encodings
   localparam logic [1:0] BOSTA = 2'd0;
   localparam logic [1:0] ISTEK = 2'd1;
   localparam logic [1:0] BEKLE = 2'd2;

   // Default address-decode geometry
   localparam int VARSAYILAN_BOLGE_BITI      = 29;
   localparam int VARSAYILAN_CIHAZ_SECIM_LSB = 16;
   localparam int VARSAYILAN_CIHAZ_SECIM_BIT = 2;

   // Device indices on the select field
   localparam int CIHAZ_UART = 0;
   localparam int CIHAZ_SPI  = 1;
   localparam int CIHAZ_PWM  = 2;

   // One core request as latched by the controller and broadcast to devices
   typedef struct packed {
      logic [31:0] adres;
      logic [31:0] veri;
      logic [3:0]  maske;
      logic        yaz;
   } istek_t;

endpackage

// File: rtl/cevre_veriyolu_denetleyici_zaman_asimi_sayaci.sv
// Clear/enable cycle counter with a terminal-count flag. The count saturates
// at ZAMAN_ASIMI so the flag stays up until the owner clears it.
module zaman_asimi_sayaci #(
   parameter int ZAMAN_ASIMI = 255,
   parameter int SAYAC_BIT   = (ZAMAN_ASIMI < 2) ? 1 : $clog2(ZAMAN_ASIMI + 1)
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic temizle_i,
   input  logic etkin_i,
   output logic doldu_o
);

   logic [SAYAC_BIT-1:0] sayi;

   assign doldu_o = (sayi == SAYAC_BIT'(ZAMAN_ASIMI));

   // Count enabled cycles; clear has priority over counting
   always_ff @(posedge clk_i) begin
      // NOTE: registers use non-blocking assignment so every flop samples
      // pre-edge values and simulation matches the synthesised netlist.
      if (rst_i || temizle_i) begin
         sayi <= '0;
      end else if (etkin_i && !doldu_o) begin
         sayi <= sayi + 1'b1;
      end
   end

endmodule

// File: rtl/cevre_veriyolu_denetleyici.sv
// Peripheral-bus controller: registers one core request, decodes the target
// device from the address, runs a valid/busy handshake to it, waits for read
// data when needed and returns a one-cycle completion (or error) pulse.
module cevre_veriyolu_denetleyici
   import cevre_veriyolu_denetleyici_pkg::*;
#(
   parameter int CIHAZ_SAYISI    = 4,
   parameter int CIHAZ_SECIM_LSB = VARSAYILAN_CIHAZ_SECIM_LSB,
   parameter int CIHAZ_SECIM_BIT = VARSAYILAN_CIHAZ_SECIM_BIT,
   parameter int BOLGE_BITI      = VARSAYILAN_BOLGE_BITI,
   parameter int ZAMAN_ASIMI     = 255
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      cekirdek_istek_i,
   input  logic [31:0]               cekirdek_adres_i,
   input  logic [31:0]               cekirdek_veri_i,
   input  logic [3:0]                cekirdek_maske_i,
   input  logic                      cekirdek_yaz_i,
   output logic                      cekirdek_mesgul_o,
   output logic                      cekirdek_hazir_o,
   output logic                      cekirdek_hata_o,
   output logic [31:0]               cekirdek_veri_o,
   output logic [31:0]               cihaz_adres_o,
   output logic [31:0]               cihaz_veri_o,
   output logic [3:0]                cihaz_maske_o,
   output logic                      cihaz_yaz_o,
   output logic [CIHAZ_SAYISI-1:0]   cihaz_gecerli_o,
   input  logic [CIHAZ_SAYISI-1:0]   cihaz_mesgul_i,
   input  logic [32*CIHAZ_SAYISI-1:0] cihaz_oku_veri_i,
   input  logic [CIHAZ_SAYISI-1:0]   cihaz_veri_gecerli_i
);

   localparam logic [CIHAZ_SAYISI-1:0]    TEK_BIT  = CIHAZ_SAYISI'(1);
   localparam logic [CIHAZ_SECIM_BIT:0]   SAYI_SEL = (CIHAZ_SECIM_BIT + 1)'(CIHAZ_SAYISI);

   logic [1:0]                 durum;
   istek_t                     istek_q;
   logic [CIHAZ_SECIM_BIT-1:0] sel_q;

   logic [CIHAZ_SECIM_BIT-1:0] sel_w;
   logic                       cozum_ok;
   logic [CIHAZ_SAYISI-1:0]    secim_maskesi;
   logic                       kabul;
   logic                       veri_geldi;
   logic [31:0]                secili_veri;
   logic                       zaman_doldu;

   // Decode of the incoming core request
   assign sel_w    = cekirdek_adres_i[CIHAZ_SECIM_LSB +: CIHAZ_SECIM_BIT];
   assign cozum_ok = cekirdek_adres_i[BOLGE_BITI] && ({1'b0, sel_w} < SAYI_SEL);

   // Handshake qualifiers for the device selected by the latched request
   assign secim_maskesi = TEK_BIT << sel_q;
   assign kabul         = |(cihaz_gecerli_o & ~cihaz_mesgul_i);
   assign veri_geldi    = |(cihaz_veri_gecerli_i & secim_maskesi);

   assign cekirdek_mesgul_o = (durum != BOSTA);

   assign cihaz_adres_o = istek_q.adres;
   assign cihaz_veri_o  = istek_q.veri;
   assign cihaz_maske_o = istek_q.maske;
   assign cihaz_yaz_o   = istek_q.yaz;

   // Read-data mux: pick the 32-bit lane of the selected device
   always_comb begin
      // NOTE: a default before the loop keeps every path assigned, so no
      // latch is inferred for secili_veri.
      secili_veri = '0;
      for (int k = 0; k < CIHAZ_SAYISI; k++) begin
         if (sel_q == CIHAZ_SECIM_BIT'(k)) begin
            secili_veri = cihaz_oku_veri_i[32*k +: 32];
         end
      end
   end

   // Cycle budget for ISTEK+BEKLE; held clear while idle so it starts at 0
   zaman_asimi_sayaci #(
      .ZAMAN_ASIMI (ZAMAN_ASIMI)
   ) u_zaman_asimi_sayaci (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .temizle_i (durum == BOSTA),
      .etkin_i   (durum != BOSTA),
      .doldu_o   (zaman_doldu)
   );

   // Controller FSM with registered handshake and completion outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         durum            <= BOSTA;
         istek_q          <= '0;
         sel_q            <= '0;
         cihaz_gecerli_o  <= '0;
         cekirdek_hazir_o <= 1'b0;
         cekirdek_hata_o  <= 1'b0;
         cekirdek_veri_o  <= '0;
      end else begin
         // Completion outputs are single-cycle pulses unless set below
         cekirdek_hazir_o <= 1'b0;
         cekirdek_hata_o  <= 1'b0;
         cekirdek_veri_o  <= '0;

         case (durum)
            BOSTA: begin
               if (cekirdek_istek_i) begin
                  istek_q <= '{adres: cekirdek_adres_i, veri: cekirdek_veri_i,
                               maske: cekirdek_maske_i, yaz: cekirdek_yaz_i};
                  sel_q   <= sel_w;
                  if (cozum_ok) begin
                     durum           <= ISTEK;
                     cihaz_gecerli_o <= TEK_BIT << sel_w;
                  end else begin
                     cekirdek_hazir_o <= 1'b1;
                     cekirdek_hata_o  <= 1'b1;
                  end
               end
            end

            ISTEK: begin
               if (kabul && istek_q.yaz) begin
                  // Accepted write is the completion
                  cihaz_gecerli_o  <= '0;
                  cekirdek_hazir_o <= 1'b1;
                  durum            <= BOSTA;
               end else if (zaman_doldu) begin
                  cihaz_gecerli_o  <= '0;
                  cekirdek_hazir_o <= 1'b1;
                  cekirdek_hata_o  <= 1'b1;
                  durum            <= BOSTA;
               end else if (kabul) begin
                  // Accepted read: data valid in this cycle is not honoured
                  cihaz_gecerli_o <= '0;
                  durum           <= BEKLE;
               end
            end

            BEKLE: begin
               if (veri_geldi) begin
                  cekirdek_hazir_o <= 1'b1;
                  cekirdek_veri_o  <= secili_veri;
                  durum            <= BOSTA;
               end else if (zaman_doldu) begin
                  cekirdek_hazir_o <= 1'b1;
                  cekirdek_hata_o  <= 1'b1;
                  durum            <= BOSTA;
               end
            end

            default: begin
               cihaz_gecerli_o <= '0;
               durum           <= BOSTA;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cevre_veriyolu_denetleyici.sv
// Directed bench for cevre_veriyolu_denetleyici with three devices and an
// 8-cycle timeout. Inputs change 1 ns after a rising edge; outputs are read
// at the same point, i.e. they reflect the registers updated by that edge.
module tb_cevre_veriyolu_denetleyici;
   import cevre_veriyolu_denetleyici_pkg::*;

   localparam int N  = 3;
   localparam int ZA = 8;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              cekirdek_istek_i;
   logic [31:0]       cekirdek_adres_i;
   logic [31:0]       cekirdek_veri_i;
   logic [3:0]        cekirdek_maske_i;
   logic              cekirdek_yaz_i;
   logic              cekirdek_mesgul_o;
   logic              cekirdek_hazir_o;
   logic              cekirdek_hata_o;
   logic [31:0]       cekirdek_veri_o;
   logic [31:0]       cihaz_adres_o;
   logic [31:0]       cihaz_veri_o;
   logic [3:0]        cihaz_maske_o;
   logic              cihaz_yaz_o;
   logic [N-1:0]      cihaz_gecerli_o;
   logic [N-1:0]      cihaz_mesgul_i;
   logic [32*N-1:0]   cihaz_oku_veri_i;
   logic [N-1:0]      cihaz_veri_gecerli_i;

   int kontrol_sayisi = 0;
   int hata_sayisi    = 0;

   cevre_veriyolu_denetleyici #(
      .CIHAZ_SAYISI (N),
      .ZAMAN_ASIMI  (ZA)
   ) dut (
      .clk_i                (clk_i),
      .rst_i                (rst_i),
      .cekirdek_istek_i     (cekirdek_istek_i),
      .cekirdek_adres_i     (cekirdek_adres_i),
      .cekirdek_veri_i      (cekirdek_veri_i),
      .cekirdek_maske_i     (cekirdek_maske_i),
      .cekirdek_yaz_i       (cekirdek_yaz_i),
      .cekirdek_mesgul_o    (cekirdek_mesgul_o),
      .cekirdek_hazir_o     (cekirdek_hazir_o),
      .cekirdek_hata_o      (cekirdek_hata_o),
      .cekirdek_veri_o      (cekirdek_veri_o),
      .cihaz_adres_o        (cihaz_adres_o),
      .cihaz_veri_o         (cihaz_veri_o),
      .cihaz_maske_o        (cihaz_maske_o),
      .cihaz_yaz_o          (cihaz_yaz_o),
      .cihaz_gecerli_o      (cihaz_gecerli_o),
      .cihaz_mesgul_i       (cihaz_mesgul_i),
      .cihaz_oku_veri_i     (cihaz_oku_veri_i),
      .cihaz_veri_gecerli_i (cihaz_veri_gecerli_i)
   );

   always #5 clk_i = ~clk_i;

   // Global time limit so the run always ends
   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic kontrol(input string etiket, input logic [31:0] gozlenen,
                          input logic [31:0] beklenen);
      kontrol_sayisi++;
      if (gozlenen !== beklenen) begin
         hata_sayisi++;
         $display("FAIL %s: observed=%h required=%h", etiket, gozlenen, beklenen);
      end
   endtask

   task automatic adim();
      @(posedge clk_i);
      #1;
   endtask

   task automatic istek_sur(input logic [31:0] adres, input logic [31:0] veri,
                            input logic yaz);
      cekirdek_istek_i = 1'b1;
      cekirdek_adres_i = adres;
      cekirdek_veri_i  = veri;
      cekirdek_maske_i = 4'hF;
      cekirdek_yaz_i   = yaz;
   endtask

   task automatic sessiz_kontrol(input string etiket);
      kontrol({etiket, "_mesgul"}, 32'(cekirdek_mesgul_o), 32'd0);
      kontrol({etiket, "_hazir"},  32'(cekirdek_hazir_o),  32'd0);
      kontrol({etiket, "_hata"},   32'(cekirdek_hata_o),   32'd0);
      kontrol({etiket, "_veri"},   cekirdek_veri_o,        32'd0);
      kontrol({etiket, "_gecerli"}, 32'(cihaz_gecerli_o),  32'd0);
      kontrol({etiket, "_cadres"}, cihaz_adres_o,          32'd0);
      kontrol({etiket, "_cveri"},  cihaz_veri_o,           32'd0);
      kontrol({etiket, "_cmaske"}, 32'(cihaz_maske_o),     32'd0);
      kontrol({etiket, "_cyaz"},   32'(cihaz_yaz_o),       32'd0);
   endtask

   initial begin
      rst_i                = 1'b1;
      cekirdek_istek_i     = 1'b0;
      cekirdek_adres_i     = '0;
      cekirdek_veri_i      = '0;
      cekirdek_maske_i     = '0;
      cekirdek_yaz_i       = 1'b0;
      cihaz_mesgul_i       = '0;
      cihaz_oku_veri_i     = '0;
      cihaz_veri_gecerli_i = '0;

      // Reset state
      adim();
      adim();
      sessiz_kontrol("reset");
      rst_i = 1'b0;
      adim();

      // UART write: valid at N+1 only, completion at N+2
      istek_sur(32'h2000_0000 | (CIHAZ_UART << 16), 32'h1234_5678, 1'b1);
      adim();
      cekirdek_istek_i = 1'b0;
      kontrol("uart_gecerli", 32'(cihaz_gecerli_o), 32'b001);
      kontrol("uart_mesgul",  32'(cekirdek_mesgul_o), 32'd1);
      kontrol("uart_hazir0",  32'(cekirdek_hazir_o), 32'd0);
      kontrol("uart_cadres",  cihaz_adres_o, 32'h2000_0000);
      kontrol("uart_cveri",   cihaz_veri_o, 32'h1234_5678);
      kontrol("uart_cyaz",    32'(cihaz_yaz_o), 32'd1);
      adim();
      kontrol("uart_hazir",   32'(cekirdek_hazir_o), 32'd1);
      kontrol("uart_hata",    32'(cekirdek_hata_o), 32'd0);
      kontrol("uart_gecerli2", 32'(cihaz_gecerli_o), 32'd0);
      kontrol("uart_mesgul2", 32'(cekirdek_mesgul_o), 32'd0);
      adim();
      kontrol("uart_hazir_pulse", 32'(cekirdek_hazir_o), 32'd0);

      // SPI read at 0x2001_0004; data 3 cycles after accept
      istek_sur(32'h2001_0004, 32'h0, 1'b0);
      adim();                                   // N+1: accept cycle
      cekirdek_istek_i = 1'b0;
      kontrol("spi_gecerli", 32'(cihaz_gecerli_o), 32'b010);
      cihaz_veri_gecerli_i = 3'b010;            // same cycle as accept: ignored
      cihaz_oku_veri_i[32*CIHAZ_SPI +: 32] = 32'hBAD0_0001;
      adim();                                   // N+2
      kontrol("spi_gecerli_off", 32'(cihaz_gecerli_o), 32'd0);
      kontrol("spi_mesgul_a", 32'(cekirdek_mesgul_o), 32'd1);
      kontrol("spi_hazir_a",  32'(cekirdek_hazir_o), 32'd0);
      cihaz_veri_gecerli_i = 3'b001;            // non-selected device: ignored
      cihaz_oku_veri_i[32*CIHAZ_UART +: 32] = 32'h1111_1111;
      adim();                                   // N+3
      kontrol("spi_mesgul_b", 32'(cekirdek_mesgul_o), 32'd1);
      kontrol("spi_hazir_b",  32'(cekirdek_hazir_o), 32'd0);
      cihaz_veri_gecerli_i = '0;
      adim();                                   // N+4: device returns data
      kontrol("spi_mesgul_c", 32'(cekirdek_mesgul_o), 32'd1);
      kontrol("spi_hazir_c",  32'(cekirdek_hazir_o), 32'd0);
      cihaz_veri_gecerli_i = 3'b010;
      cihaz_oku_veri_i[32*CIHAZ_SPI +: 32] = 32'hDEAD_BEEF;
      adim();                                   // N+5
      cihaz_veri_gecerli_i = '0;
      kontrol("spi_hazir",  32'(cekirdek_hazir_o), 32'd1);
      kontrol("spi_hata",   32'(cekirdek_hata_o), 32'd0);
      kontrol("spi_veri",   cekirdek_veri_o, 32'hDEAD_BEEF);
      kontrol("spi_mesgul_d", 32'(cekirdek_mesgul_o), 32'd0);
      adim();
      kontrol("spi_hazir_pulse", 32'(cekirdek_hazir_o), 32'd0);
      kontrol("spi_veri_zero",   cekirdek_veri_o, 32'd0);
      kontrol("spi_cadres_hold", cihaz_adres_o, 32'h2001_0004);

      // PWM write with device busy for 5 cycles
      cihaz_mesgul_i = 3'b100;
      istek_sur(32'h2000_0000 | (CIHAZ_PWM << 16), 32'hA5A5_0000, 1'b1);
      adim();
      cekirdek_istek_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         kontrol($sformatf("pwm_gecerli_busy%0d", i), 32'(cihaz_gecerli_o), 32'b100);
         kontrol($sformatf("pwm_hazir_busy%0d", i), 32'(cekirdek_hazir_o), 32'd0);
         if (i < 4) adim();
      end
      adim();                                   // accept cycle
      cihaz_mesgul_i = '0;
      kontrol("pwm_gecerli_accept", 32'(cihaz_gecerli_o), 32'b100);
      adim();
      kontrol("pwm_hazir",   32'(cekirdek_hazir_o), 32'd1);
      kontrol("pwm_hata",    32'(cekirdek_hata_o), 32'd0);
      kontrol("pwm_gecerli_off", 32'(cihaz_gecerli_o), 32'd0);

      // Decode errors: outside region, then select 3 with only 3 devices
      istek_sur(32'h0000_1000, 32'h0, 1'b0);
      adim();
      kontrol("dec1_hazir",   32'(cekirdek_hazir_o), 32'd1);
      kontrol("dec1_hata",    32'(cekirdek_hata_o), 32'd1);
      kontrol("dec1_veri",    cekirdek_veri_o, 32'd0);
      kontrol("dec1_gecerli", 32'(cihaz_gecerli_o), 32'd0);
      kontrol("dec1_mesgul",  32'(cekirdek_mesgul_o), 32'd0);
      istek_sur(32'h2003_0000, 32'h0, 1'b1);
      adim();
      cekirdek_istek_i = 1'b0;
      kontrol("dec2_hazir",   32'(cekirdek_hazir_o), 32'd1);
      kontrol("dec2_hata",    32'(cekirdek_hata_o), 32'd1);
      kontrol("dec2_gecerli", 32'(cihaz_gecerli_o), 32'd0);
      adim();
      kontrol("dec2_hazir_pulse", 32'(cekirdek_hazir_o), 32'd0);

      // Timeout on a UART read: counter hits 8 at N+9, error pulse at N+10
      istek_sur(32'h2000_0008, 32'h0, 1'b0);
      for (int i = 1; i <= 9; i++) begin
         adim();
         cekirdek_istek_i = 1'b0;
         kontrol($sformatf("to_hazir%0d", i), 32'(cekirdek_hazir_o), 32'd0);
         kontrol($sformatf("to_mesgul%0d", i), 32'(cekirdek_mesgul_o), 32'd1);
      end
      adim();                                   // N+10
      kontrol("to_hazir",  32'(cekirdek_hazir_o), 32'd1);
      kontrol("to_hata",   32'(cekirdek_hata_o), 32'd1);
      kontrol("to_veri",   cekirdek_veri_o, 32'd0);
      kontrol("to_mesgul", 32'(cekirdek_mesgul_o), 32'd0);
      // Late data from the timed-out device plus a back-to-back SPI write
      cihaz_veri_gecerli_i = 3'b001;
      cihaz_oku_veri_i[32*CIHAZ_UART +: 32] = 32'hCAFE_F00D;
      istek_sur(32'h2001_0000, 32'h5555_AAAA, 1'b1);
      adim();
      cekirdek_istek_i     = 1'b0;
      cihaz_veri_gecerli_i = '0;
      kontrol("b2b_gecerli", 32'(cihaz_gecerli_o), 32'b010);
      kontrol("b2b_hazir0",  32'(cekirdek_hazir_o), 32'd0);
      kontrol("b2b_veri0",   cekirdek_veri_o, 32'd0);
      adim();
      kontrol("b2b_hazir",   32'(cekirdek_hazir_o), 32'd1);
      kontrol("b2b_hata",    32'(cekirdek_hata_o), 32'd0);

      // Reset in BEKLE aborts without a completion pulse
      adim();
      istek_sur(32'h2001_0000, 32'h0, 1'b0);
      adim();                                   // accept
      cekirdek_istek_i = 1'b0;
      adim();                                   // BEKLE
      kontrol("rst_mid_mesgul", 32'(cekirdek_mesgul_o), 32'd1);
      rst_i = 1'b1;
      cihaz_veri_gecerli_i = 3'b010;
      adim();
      rst_i = 1'b0;
      cihaz_veri_gecerli_i = '0;
      sessiz_kontrol("rst_mid");
      adim();
      kontrol("rst_after_hazir", 32'(cekirdek_hazir_o), 32'd0);
      istek_sur(32'h2000_0000, 32'h0BAD_CAFE, 1'b1);
      adim();
      cekirdek_istek_i = 1'b0;
      kontrol("post_rst_gecerli", 32'(cihaz_gecerli_o), 32'b001);
      adim();
      kontrol("post_rst_hazir", 32'(cekirdek_hazir_o), 32'd1);
      kontrol("post_rst_hata",  32'(cekirdek_hata_o), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               kontrol_sayisi, hata_sayisi);
      $finish;
   end

endmodule
